vx_mem_line_responder: RTL
==========================

Name: vx_mem_line_responder

Overview:
- Memory-side responder for the cache's line-granular memory bus; terminates the master port that a cache wrapper drives.
- Accepts read/write line requests, stores lines in an internal byte-enabled array, and returns read data with the original tag after a fixed latency.
- A bounded response queue applies backpressure.
- Used as a behavioural/FPGA-local backing store and as a bench target for cache verification.

Parameters:
- LINE_SIZE, 64, bytes per line; data width = 8*LINE_SIZE.
- ADDR_WIDTH, 26, line-address width.
- TAG_WIDTH, 8, request tag width, returned unmodified on the response.
- MEM_DEPTH, 256, lines in the array (power of two); index = addr[CLOG2(MEM_DEPTH)-1:0]; upper address bits ignored (aliasing).
- LATENCY, 4, cycles from read accept to earliest rsp_valid; must be ≥1.
- RSP_QUEUE, 4, maximum outstanding reads (pipeline plus queue); must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mem_req_valid  in  1  request valid.
- mem_req_rw  in  1  1=write, 0=read.
- mem_req_addr  in  ADDR_WIDTH  line address.
- mem_req_byteen  in  LINE_SIZE  write byte enables; ignored on reads.
- mem_req_data  in  8*LINE_SIZE  write data.
- mem_req_tag  in  TAG_WIDTH  request tag.
- mem_req_ready  out  1  request accepted when valid&&ready.
- mem_rsp_valid  out  1  read response valid.
- mem_rsp_data  out  8*LINE_SIZE  read line data.
- mem_rsp_tag  out  TAG_WIDTH  tag of the answered read.
- mem_rsp_ready  in  1  consumer accepts response.
- rd_count  out  32  accepted reads; wraps at 2^32.
- wr_count  out  32  accepted writes; wraps at 2^32.

Behaviour:
- Reset (reset=0, asynchronous): clears pipeline valid bits, queue pointers, outstanding counter, rd_count and wr_count. Outputs go to mem_rsp_valid=0, mem_req_ready=1, counts=0. mem_rsp_data/tag are don't-care while invalid. Array contents are NOT cleared and keep prior values.
- Reset mid-operation: all in-flight reads are dropped; no response for them is ever emitted after reset deassertion.
- Outstanding counter `outst` (width CLOG2(RSP_QUEUE+1)):
  - increments on read accept; decrements on response fire (mem_rsp_valid&&mem_rsp_ready);
  - both in the same cycle leave it unchanged.
- mem_req_ready = (outst < RSP_QUEUE), combinational from registered state, for reads and writes alike. Writes stall while reads are saturated, which keeps ordering simple.
- Write accept:
  - for each byte b with byteen[b]=1, the array line at the index gets byte b updated at the accept clock edge; bytes with byteen=0 are unchanged;
  - no response is generated; wr_count++.
- Read accept:
  - array line is read at the accept cycle, reflecting all writes accepted in strictly earlier cycles;
  - {data, tag} enter stage 0 of a LATENCY-deep valid/data shift pipeline; rd_count++.
- Pipeline:
  - advances every cycle and never stalls;
  - the last stage pushes into a RSP_QUEUE-entry FIFO;
  - the credit scheme guarantees the FIFO never overflows, and an assertion fires on push-when-full.
- Response:
  - mem_rsp_valid = FIFO non-empty; data/tag come from the FIFO head (first-word-fallthrough);
  - a read accepted at edge t with an empty FIFO gives rsp_valid high in the cycle after edge t+LATENCY, i.e. LATENCY cycles after acceptance;
  - responses are returned in acceptance order.
- FIFO push and pop in the same cycle are legal, including at full. Wrap-around of the read/write pointers is modulo RSP_QUEUE.
- Back-to-back reads: one per cycle sustained while mem_rsp_ready=1 and RSP_QUEUE ≥ LATENCY+1. Otherwise throughput is credit-limited.
- Holding mem_rsp_valid: once asserted, mem_rsp_valid stays high and data/tag stay stable until fire.

Test Plan:
- Write addr=0x5, byteen=all-ones, data=0xA5 repeated; then read addr=0x5, tag=0x3C → one response after 4 cycles, data=0xA5 repeated, tag=0x3C; wr_count=1, rd_count=1.
- Partial write addr=0x5, byteen=0x1, data byte0=0x11 over the prior line; read → byte0=0x11, bytes1..63=0xA5.
- rsp_ready held 0; issue reads tags 1..6 → exactly 4 accepted; mem_req_ready=0 afterwards. Release rsp_ready → tags 1,2,3,4 returned in order; ready reasserts the cycle after the first fire.
- Simultaneous read accept and response fire at outst=4 is impossible (ready=0); at outst=3 → outst stays 3 and ready stays 1.
- Aliasing: write addr=0x105, read addr=0x005 (MEM_DEPTH=256) → returns the data written at 0x105.
- Issue 2 reads, assert reset low 2 cycles after acceptance for 1 cycle → no mem_rsp_valid ever; counts=0; ready=1; a subsequent read still returns the previously written array data.

Source files
------------

// File: rtl/vx_mem_line_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_mem_line_responder - line memory responder: byte-enabled array, fixed-   |
// | latency read pipeline, credit-bounded response FIFO.          Rev 1.0       |
// +----------------------------------------------------------------------------+
module vx_mem_line_responder #(
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int LATENCY    = 4,
  parameter int RSP_QUEUE  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  input  logic                   mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic [LINE_SIZE-1:0]   mem_req_byteen,
  input  logic [8*LINE_SIZE-1:0] mem_req_data,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag,
  output logic                   mem_req_ready,
  output logic                   mem_rsp_valid,
  output logic [8*LINE_SIZE-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
  input  logic                   mem_rsp_ready,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
);

  localparam int DATA_W = 8 * LINE_SIZE;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int OUT_W  = $clog2(RSP_QUEUE + 1);
  localparam int PTR_W  = (RSP_QUEUE > 1) ? $clog2(RSP_QUEUE) : 1;
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(RSP_QUEUE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_QUEUE - 1);

  logic             req_fire;
  logic             rd_acc;
  logic             wr_acc;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] idx;

  logic [DATA_W-1:0]    mem_q       [MEM_DEPTH];
  logic                 pipe_vld_q  [LATENCY];
  logic [DATA_W-1:0]    pipe_data_q [LATENCY];
  logic [TAG_WIDTH-1:0] pipe_tag_q  [LATENCY];
  logic [DATA_W-1:0]    fifo_data_q [RSP_QUEUE];
  logic [TAG_WIDTH-1:0] fifo_tag_q  [RSP_QUEUE];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [31:0]      rd_cnt_q, rd_cnt_d;
  logic [31:0]      wr_cnt_q, wr_cnt_d;

  // Upper address bits alias onto the same lines.
  generate
    if (ADDR_WIDTH > IDX_W) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:IDX_W];
    end
  endgenerate

  assign idx           = mem_req_addr[IDX_W-1:0];
  assign mem_req_ready = (outst_q < OUT_MAX);
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_acc        = req_fire && !mem_req_rw;
  assign wr_acc        = req_fire && mem_req_rw;
  assign push          = pipe_vld_q[LATENCY-1];
  assign mem_rsp_valid = (cnt_q != '0);
  assign pop           = mem_rsp_valid && mem_rsp_ready;
  assign mem_rsp_data  = fifo_data_q[rd_ptr_q];
  assign mem_rsp_tag   = fifo_tag_q[rd_ptr_q];
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

  // Array survives reset; only the bytes enabled on the request are touched.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (mem_req_byteen[b]) begin
          mem_q[idx][8*b +: 8] <= mem_req_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_data_q[0] <= mem_q[idx];
    pipe_tag_q[0]  <= mem_req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
      pipe_tag_q[i]  <= pipe_tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[LATENCY-1];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    outst_d  = outst_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + OUT_W'(1);
      2'b01:   cnt_d = cnt_q - OUT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Credits cover pipeline plus FIFO, so the FIFO can never overflow.
    case ({rd_acc, pop})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (rd_acc) rd_cnt_d = rd_cnt_q + 32'd1;
    if (wr_acc) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                  !(push && (cnt_q == OUT_MAX) && !pop));
`endif

endmodule
`default_nettype wire
